multi_timer: RTL and testbench
==============================

// Module: multi_timer
// PURPOSE
//  Parametrised N-channel bus timer; successor to the single-channel timer on the peripheral bus.
//  Each channel has:
//   - an independent up/down counter with a per-channel prescaler;
//   - one-shot or periodic mode;
//   - a sticky pending flag with interrupt enable.
//  All channels share one bus slave port (cs/as/rw/rdy handshake) and one OR-combined IRQ line.
// PARAMETERS
//  N_CH     4   number of channels (1..16)
//  CNT_W    32  counter/LOAD width (1..DATA_W)
//  DATA_W   32  bus data width
//  PRESC_W  8   prescaler field width (<= 8)
//  ADDR_W   $clog2(N_CH)+2  bus address width (derived; localparam)
// PORTS
//  clk         in   1       clock; all logic on posedge
//  rest        in   1       synchronous reset, active-high
//  Timer_cs    in   1       chip select
//  Timer_as    in   1       address strobe
//  Timer_rw    in   1       1 = read, 0 = write
//  Timer_rdy   out  1       access acknowledge
//  Timer_addr  in   ADDR_W  {channel, reg[1:0]}
//  Timer_wr_data in DATA_W  write data
//  Timer_rd_data out DATA_W read data
//  Timer_irq   out  1       OR of (PEND & IE) over all channels
// BEHAVIOUR
//  Reset
//   - one clock and reset only; reset is synchronous and active-high.
//   - rdy=0, rd_data=0, irq=0.
//   - per channel: EN=0, DIR=0, MODE=0, IE=0, PRESC=0, LOAD=all ones, COUNT=0, PEND=0, prescaler cnt=0.
//   - reset mid-count aborts everything at that edge.
//  Register map (reg = addr[1:0]; channel = addr[ADDR_W-1:2])
//   - 0 CTRL: [0] EN, [1] DIR (0 up, 1 down), [2] MODE (0 one-shot, 1 periodic), [3] IE, [8+:PRESC_W] PRESC.
//   - 1 LOAD: terminal value (up) / reload value (down).
//   - 2 COUNT: read live value; write overwrites the counter.
//   - 3 STATUS: [0] PEND (write 1 to clear), [1] EN mirror (read-only).
//  Handshake
//   - access = cs & as.
//   - rdy is registered: asserted in the cycle after an access, otherwise 0.
//   - read data is registered with the same 1-cycle latency.
//   - rd_data holds its value when there is no read.
//   - reads are CNT_W values zero-extended; writes are truncated to field width.
//   - channel index >= N_CH: reads return 0, writes are ignored, rdy still asserts.
//  Counting
//   - EN 0->1 via CTRL write: COUNT <= 0 (up) or LOAD (down); prescaler cnt <= 0.
//   - prescaler counts 0..PRESC; tick when cnt==PRESC, then cnt wraps to 0. PRESC=0 gives a tick every clk.
//   - on tick with EN=1, terminal is COUNT==LOAD (up) or COUNT==0 (down):
//     - terminal: PEND<=1.
//       - periodic: COUNT reloads to 0 (up) or LOAD (down).
//       - one-shot: EN<=0 and COUNT holds.
//     - non-terminal: COUNT +/- 1, wrapping modulo 2^CNT_W.
//   - EN=0: COUNT and prescaler freeze; no clear-on-stop.
//   - LOAD written while running is compared immediately.
//     - up-count with LOAD < COUNT runs until wrap and then matches.
//   - LOAD=0 up periodic: PEND sets on every tick.
//  Simultaneous events
//   - COUNT bus write beats a tick update in the same cycle.
//   - PEND set by terminal beats a W1C in the same cycle.
//   - a CTRL write clearing EN beats one-shot auto-clear; the result is the same either way.
//  IRQ
//   - registered: irq <= |(PEND & IE), one cycle after PEND sets.
//   - level output; stays high until every enabled PEND is cleared.
// STRUCTURE
//  - shared package/include global.v: register offsets, CTRL bit positions, MODE/DIR encodings.
//  - sub-module timer_channel (one per channel, generate loop):
//    - holds CTRL/LOAD/COUNT/PEND and the prescaler;
//    - inputs: decoded write strobes and wr_data;
//    - outputs: register values and pend_irq.
//  - top level: address decode, read mux, rdy/rd_data regs, IRQ OR-reduction.
// TESTING
//  1. Reset: all regs read back reset values.
//     - LOAD reads 32'hFFFF_FFFF.
//     - irq=0 and rdy=0 in the cycle after reset.
//  2. Ch0 up, one-shot, LOAD=5, PRESC=0, IE=1.
//     - PEND sets 6 clk after EN and COUNT stays 5.
//     - EN clears and irq rises the next cycle.
//     - W1C STATUS drops irq one cycle later.
//  3. Ch1 down, periodic, LOAD=3, PRESC=2.
//     - terminal every 12 clk: COUNT sequence 3,2,1,0,3..., each value held 3 clk.
//  4. Ch2 periodic, LOAD=0: PEND sets on first tick.
//     - issue W1C in the same cycle as a terminal: PEND stays 1.
//  5. Access to channel N_CH: read returns 0 with rdy.
//     - write leaves every channel unchanged.
//     - check 1-cycle rdy/rd_data latency on all reg offsets.
//  6. Assert rest while two channels run: next edge all state is reset and irq=0.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel bus timer: register offsets,
// CTRL/STATUS bit positions and the DIR/MODE encodings.
package multi_timer_pkg;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_LOAD   = 2'd1,
      REG_COUNT  = 2'd2,
      REG_STATUS = 2'd3
   } reg_sel_e;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_DIR_BIT   = 1;
   localparam int CTRL_MODE_BIT  = 2;
   localparam int CTRL_IE_BIT    = 3;
   localparam int CTRL_PRESC_LSB = 8;

   localparam int STAT_PEND_BIT  = 0;
   localparam int STAT_EN_BIT    = 1;

   localparam logic DIR_UP        = 1'b0;
   localparam logic DIR_DOWN      = 1'b1;
   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // Address is {channel, reg[1:0]}.
   function automatic int addr_width(input int n_ch);
      return $clog2(n_ch) + 2;
   endfunction

endpackage

// File: rtl/multi_timer_if.sv
// Peripheral bus port of the timer: cs/as/rw/rdy handshake, data and IRQ.
interface multi_timer_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   logic              cs;
   logic              as;
   logic              rw;
   logic              rdy;
   logic              irq;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;

   modport master (output cs, as, rw, addr, wr_data, input rdy, rd_data, irq);
   modport slave  (input cs, as, rw, addr, wr_data, output rdy, rd_data, irq);
endinterface

// File: rtl/multi_timer_channel.sv
// One timer channel: CTRL/LOAD/COUNT/PEND state, prescaler and up/down
// counter with one-shot or periodic terminal handling.
module multi_timer_channel
   import multi_timer_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int DATA_W  = 32,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rest,
   input  logic               wr_ctrl,
   input  logic               wr_load,
   input  logic               wr_count,
   input  logic               wr_status,
   input  logic [DATA_W-1:0]  wr_data,
   output logic               en,
   output logic               dir,
   output logic               mode,
   output logic               ie,
   output logic [PRESC_W-1:0] presc,
   output logic [CNT_W-1:0]   load,
   output logic [CNT_W-1:0]   count,
   output logic               pend,
   output logic               pend_irq
);

   logic [PRESC_W-1:0] pcnt;
   logic               tick;
   logic               terminal;
   logic               unused_wr_bits;

   assign tick           = en && (pcnt == presc);
   assign terminal       = (dir == DIR_DOWN) ? (count == '0) : (count == load);
   assign pend_irq       = pend & ie;
   assign unused_wr_bits = ^wr_data;

   // Later assignments win: a terminal set overrides W1C, a CTRL write
   // overrides one-shot auto-disable, and a COUNT write overrides the tick.
   always_ff @(posedge clk) begin
      if (rest) begin
         en    <= 1'b0;
         dir   <= DIR_UP;
         mode  <= MODE_ONESHOT;
         ie    <= 1'b0;
         presc <= '0;
         load  <= '1;
         count <= '0;
         pend  <= 1'b0;
         pcnt  <= '0;
      end else begin
         if (wr_status && wr_data[STAT_PEND_BIT])
            pend <= 1'b0;

         if (tick) begin
            pcnt <= '0;
            if (terminal) begin
               pend <= 1'b1;
               if (mode == MODE_PERIODIC)
                  count <= (dir == DIR_DOWN) ? load : '0;
               else
                  en <= 1'b0;
            end else begin
               count <= (dir == DIR_DOWN) ? count - CNT_W'(1) : count + CNT_W'(1);
            end
         end else if (en) begin
            pcnt <= pcnt + PRESC_W'(1);
         end

         if (wr_ctrl) begin
            en    <= wr_data[CTRL_EN_BIT];
            dir   <= wr_data[CTRL_DIR_BIT];
            mode  <= wr_data[CTRL_MODE_BIT];
            ie    <= wr_data[CTRL_IE_BIT];
            presc <= wr_data[CTRL_PRESC_LSB +: PRESC_W];
            if (!en && wr_data[CTRL_EN_BIT]) begin
               count <= (wr_data[CTRL_DIR_BIT] == DIR_DOWN) ? load : '0;
               pcnt  <= '0;
            end
         end

         if (wr_load)
            load <= wr_data[CNT_W-1:0];

         if (wr_count)
            count <= wr_data[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/multi_timer.sv
// N-channel bus timer: address decode, read mux, registered rdy/rd_data
// and the OR-combined interrupt line over all channels.
module multi_timer
   import multi_timer_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CNT_W   = 32,
   parameter int DATA_W  = 32,
   parameter int PRESC_W = 8
) (
   input logic          clk,
   input logic          rest,
   multi_timer_if.slave Timer
);

   localparam int ADDR_W = addr_width(N_CH);
   localparam int CH_W   = (ADDR_W > 2) ? ADDR_W - 2 : 1;

   logic              access;
   logic              wr_access;
   logic              ch_valid;
   logic [CH_W-1:0]   ch_idx;
   reg_sel_e          reg_sel;
   logic [DATA_W-1:0] rd_next;

   logic               ch_en    [N_CH];
   logic               ch_dir   [N_CH];
   logic               ch_mode  [N_CH];
   logic               ch_ie    [N_CH];
   logic [PRESC_W-1:0] ch_presc [N_CH];
   logic [CNT_W-1:0]   ch_load  [N_CH];
   logic [CNT_W-1:0]   ch_count [N_CH];
   logic               ch_pend  [N_CH];
   logic [N_CH-1:0]    ch_irq;

   assign access    = Timer.cs & Timer.as;
   assign reg_sel   = reg_sel_e'(Timer.addr[1:0]);
   assign ch_idx    = CH_W'(Timer.addr >> 2);
   assign ch_valid  = (32'(ch_idx) < N_CH);
   assign wr_access = access && !Timer.rw && ch_valid;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic sel;
      assign sel = wr_access && (ch_idx == CH_W'(i));

      multi_timer_channel #(
         .CNT_W   (CNT_W),
         .DATA_W  (DATA_W),
         .PRESC_W (PRESC_W)
      ) u_ch (
         .clk       (clk),
         .rest      (rest),
         .wr_ctrl   (sel && (reg_sel == REG_CTRL)),
         .wr_load   (sel && (reg_sel == REG_LOAD)),
         .wr_count  (sel && (reg_sel == REG_COUNT)),
         .wr_status (sel && (reg_sel == REG_STATUS)),
         .wr_data   (Timer.wr_data),
         .en        (ch_en[i]),
         .dir       (ch_dir[i]),
         .mode      (ch_mode[i]),
         .ie        (ch_ie[i]),
         .presc     (ch_presc[i]),
         .load      (ch_load[i]),
         .count     (ch_count[i]),
         .pend      (ch_pend[i]),
         .pend_irq  (ch_irq[i])
      );
   end

   // Out-of-range channels fall through with zero read data.
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (ch_valid && (ch_idx == CH_W'(i))) begin
            case (reg_sel)
               REG_CTRL: begin
                  rd_next[CTRL_EN_BIT]                   = ch_en[i];
                  rd_next[CTRL_DIR_BIT]                  = ch_dir[i];
                  rd_next[CTRL_MODE_BIT]                 = ch_mode[i];
                  rd_next[CTRL_IE_BIT]                   = ch_ie[i];
                  rd_next[CTRL_PRESC_LSB +: PRESC_W]     = ch_presc[i];
               end
               REG_LOAD:  rd_next = DATA_W'(ch_load[i]);
               REG_COUNT: rd_next = DATA_W'(ch_count[i]);
               REG_STATUS: begin
                  rd_next[STAT_PEND_BIT] = ch_pend[i];
                  rd_next[STAT_EN_BIT]   = ch_en[i];
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         Timer.rdy     <= 1'b0;
         Timer.rd_data <= '0;
         Timer.irq     <= 1'b0;
      end else begin
         Timer.rdy <= access;
         if (access && Timer.rw)
            Timer.rd_data <= rd_next;
         Timer.irq <= |ch_irq;
      end
   end

endmodule

// File: tb/tb_multi_timer.sv
// Directed testbench for multi_timer with three channels, so channel index 3
// exercises the out-of-range path.
module tb_multi_timer;

   localparam int N_CH   = 3;
   localparam int ADDR_W = $clog2(N_CH) + 2;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rest;
   int   total = 0;
   int   bad   = 0;

   multi_timer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   multi_timer #(
      .N_CH    (N_CH),
      .CNT_W   (32),
      .DATA_W  (DATA_W),
      .PRESC_W (8)
   ) dut (
      .clk   (clk),
      .rest  (rest),
      .Timer (bus)
   );

   always #5 clk = ~clk;

   task automatic bus_idle();
      bus.cs      = 1'b0;
      bus.as      = 1'b0;
      bus.rw      = 1'b1;
      bus.addr    = '0;
      bus.wr_data = '0;
   endtask

   task automatic bus_write(input logic [1:0] ch, input logic [1:0] rg, input logic [31:0] data);
      bus.cs      = 1'b1;
      bus.as      = 1'b1;
      bus.rw      = 1'b0;
      bus.addr    = {ch, rg};
      bus.wr_data = data;
      @(posedge clk);
      #1;
      bus_idle();
   endtask

   task automatic bus_read(input logic [1:0] ch, input logic [1:0] rg,
                           output logic [31:0] data, output logic ack);
      bus.cs   = 1'b1;
      bus.as   = 1'b1;
      bus.rw   = 1'b1;
      bus.addr = {ch, rg};
      @(posedge clk);
      #1;
      data = bus.rd_data;
      ack  = bus.rdy;
      bus_idle();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic        a;
      logic [31:0] exp_rst [4];
      exp_rst = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
      rest = 1'b1;
      bus_idle();
      repeat (2) @(posedge clk);
      #1;
      rest = 1'b0;
      total++; if (bus.rdy !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdy got=%b exp=0", bus.rdy); end
      total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b exp=0", bus.irq); end
      total++; if (bus.rd_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
      for (int c = 0; c < N_CH; c++) begin
         for (int r = 0; r < 4; r++) begin
            bus_read(2'(c), 2'(r), d, a);
            total++; if (d !== exp_rst[r]) begin bad++; $display("[TB] FAIL reset_reg ch%0d reg%0d got=%h exp=%h", c, r, d, exp_rst[r]); end
            total++; if (a !== 1'b1) begin bad++; $display("[TB] FAIL reset_ack ch%0d reg%0d got=%b exp=1", c, r, a); end
         end
      end
   endtask

   task automatic test_oneshot_up();
      logic [31:0] d;
      logic        a;
      bus_write(2'd0, 2'd1, 32'd5);
      bus_write(2'd0, 2'd0, 32'h0000_0009);
      repeat (6) @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL oneshot_irq_early got=%b exp=0", bus.irq); end
      @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b1) begin bad++; $display("[TB] FAIL oneshot_irq_rise got=%b exp=1", bus.irq); end
      bus_read(2'd0, 2'd3, d, a);
      total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL oneshot_status got=%h exp=%h", d, 32'h1); end
      bus_read(2'd0, 2'd2, d, a);
      total++; if (d !== 32'd5) begin bad++; $display("[TB] FAIL oneshot_count got=%h exp=%h", d, 32'd5); end
      bus_read(2'd0, 2'd0, d, a);
      total++; if (d !== 32'h8) begin bad++; $display("[TB] FAIL oneshot_ctrl got=%h exp=%h", d, 32'h8); end
      bus_write(2'd0, 2'd3, 32'h1);
      total++; if (bus.irq !== 1'b1) begin bad++; $display("[TB] FAIL w1c_irq_hold got=%b exp=1", bus.irq); end
      @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL w1c_irq_drop got=%b exp=0", bus.irq); end
   endtask

   task automatic test_periodic_down();
      logic [31:0] d;
      logic [31:0] exp;
      logic        a;
      bus_write(2'd1, 2'd1, 32'd3);
      bus_write(2'd1, 2'd0, 32'h0000_0207);
      for (int i = 0; i < 13; i++) begin
         exp = 32'(3 - (i % 12) / 3);
         bus_read(2'd1, 2'd2, d, a);
         total++; if (d !== exp) begin bad++; $display("[TB] FAIL down_count step%0d got=%h exp=%h", i, d, exp); end
      end
      bus_read(2'd1, 2'd3, d, a);
      total++; if (d !== 32'h3) begin bad++; $display("[TB] FAIL down_status got=%h exp=%h", d, 32'h3); end
      total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL down_irq_masked got=%b exp=0", bus.irq); end
      bus_write(2'd1, 2'd0, 32'h0);
   endtask

   task automatic test_load_zero();
      logic [31:0] d;
      logic        a;
      bus_write(2'd2, 2'd1, 32'd0);
      bus_write(2'd2, 2'd0, 32'h0000_000D);
      total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL lz_irq_e0 got=%b exp=0", bus.irq); end
      @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL lz_irq_e1 got=%b exp=0", bus.irq); end
      @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b1) begin bad++; $display("[TB] FAIL lz_irq_e2 got=%b exp=1", bus.irq); end
      bus_write(2'd2, 2'd3, 32'h1);
      @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b1) begin bad++; $display("[TB] FAIL lz_w1c_lost got=%b exp=1", bus.irq); end
      bus_read(2'd2, 2'd3, d, a);
      total++; if (d !== 32'h3) begin bad++; $display("[TB] FAIL lz_status got=%h exp=%h", d, 32'h3); end
      bus_write(2'd2, 2'd0, 32'h0);
      @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL lz_irq_off got=%b exp=0", bus.irq); end
      bus_write(2'd2, 2'd3, 32'h1);
      bus_read(2'd2, 2'd3, d, a);
      total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL lz_status_clr got=%h exp=%h", d, 32'h0); end
   endtask

   task automatic test_bad_channel();
      logic [31:0] d;
      logic        a;
      logic [31:0] exp_load [3];
      logic [31:0] exp_ctrl [3];
      exp_load = '{32'd5, 32'd3, 32'd0};
      exp_ctrl = '{32'h8, 32'h0, 32'h0};
      @(posedge clk);
      #1;
      bus.cs   = 1'b1;
      bus.as   = 1'b1;
      bus.rw   = 1'b1;
      bus.addr = {2'd0, 2'd1};
      total++; if (bus.rdy !== 1'b0) begin bad++; $display("[TB] FAIL lat_rdy_pre got=%b exp=0", bus.rdy); end
      @(posedge clk);
      #1;
      total++; if (bus.rdy !== 1'b1) begin bad++; $display("[TB] FAIL lat_rdy got=%b exp=1", bus.rdy); end
      total++; if (bus.rd_data !== 32'd5) begin bad++; $display("[TB] FAIL lat_data got=%h exp=%h", bus.rd_data, 32'd5); end
      bus_idle();
      @(posedge clk);
      #1;
      total++; if (bus.rdy !== 1'b0) begin bad++; $display("[TB] FAIL lat_rdy_post got=%b exp=0", bus.rdy); end
      total++; if (bus.rd_data !== 32'd5) begin bad++; $display("[TB] FAIL lat_hold got=%h exp=%h", bus.rd_data, 32'd5); end
      for (int r = 0; r < 4; r++) begin
         bus_read(2'd3, 2'(r), d, a);
         total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL badch_data reg%0d got=%h exp=0", r, d); end
         total++; if (a !== 1'b1) begin bad++; $display("[TB] FAIL badch_rdy reg%0d got=%b exp=1", r, a); end
      end
      bus_write(2'd3, 2'd0, 32'h1);
      bus_write(2'd3, 2'd1, 32'h77);
      bus_write(2'd3, 2'd2, 32'h55);
      for (int c = 0; c < N_CH; c++) begin
         bus_read(2'(c), 2'd0, d, a);
         total++; if (d !== exp_ctrl[c]) begin bad++; $display("[TB] FAIL badch_ctrl ch%0d got=%h exp=%h", c, d, exp_ctrl[c]); end
      end
      bus_read(2'd0, 2'd2, d, a);
      total++; if (d !== 32'd5) begin bad++; $display("[TB] FAIL badch_count got=%h exp=%h", d, 32'd5); end
      for (int c = N_CH - 1; c >= 0; c--) begin
         bus_read(2'(c), 2'd1, d, a);
         total++; if (d !== exp_load[c]) begin bad++; $display("[TB] FAIL badch_load ch%0d got=%h exp=%h", c, d, exp_load[c]); end
      end
   endtask

   task automatic test_reset_midrun();
      logic [31:0] d;
      logic        a;
      logic [31:0] exp_rst [4];
      exp_rst = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
      bus_write(2'd0, 2'd0, 32'h0000_000D);
      bus_write(2'd1, 2'd0, 32'h0000_0207);
      repeat (10) @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b1) begin bad++; $display("[TB] FAIL midrun_irq got=%b exp=1", bus.irq); end
      rest = 1'b1;
      @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL midrun_rst_irq got=%b exp=0", bus.irq); end
      total++; if (bus.rd_data !== 32'h0) begin bad++; $display("[TB] FAIL midrun_rst_data got=%h exp=0", bus.rd_data); end
      rest = 1'b0;
      for (int c = 0; c < 2; c++) begin
         for (int r = 0; r < 4; r++) begin
            bus_read(2'(c), 2'(r), d, a);
            total++; if (d !== exp_rst[r]) begin bad++; $display("[TB] FAIL midrun_reg ch%0d reg%0d got=%h exp=%h", c, r, d, exp_rst[r]); end
         end
      end
      repeat (8) @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b0) begin bad++; $display("[TB] FAIL midrun_irq_quiet got=%b exp=0", bus.irq); end
   endtask

   initial begin
      rest = 1'b1;
      bus_idle();
      test_reset();
      test_oneshot_up();
      test_periodic_down();
      test_load_zero();
      test_bad_channel();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
